// File: rtl/fp_round_unit_pkg.sv
// Shared binary32 types and constants for the FP rounding unit.
package fp_round_unit_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float_t;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rnd_mode_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [1:0] {
    FU_FREE = 2'b00,
    FU_BUSY = 2'b01
  } fu_state_e;

  localparam logic [31:0] CANONICAL_NAN = 32'h7FC0_0000;
  localparam logic [30:0] MAX_FINITE    = 31'h7F7F_FFFF;
  localparam logic [30:0] INF_MAG       = 31'h7F80_0000;

endpackage

// File: rtl/fp_round_incr.sv
// Increment decision from sign, mantissa LSB, GRS and rounding mode.
// Purely combinational; no backpressure.
module fp_round_incr
  import fp_round_unit_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic [2:0] grs,
  input  logic [2:0] rnd_mode,
  output logic       inc,
  output logic       nx
);

  logic g, r, s;

  assign {g, r, s} = grs;
  assign nx        = g | r | s;

  always_comb begin
    inc = 1'b0;
    case (rnd_mode)
      RM_RNE:  inc = g & (r | s | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & nx;
      RM_RUP:  inc = ~sign & nx;
      RM_RMM:  inc = g;
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_round_unit.sv
// Rounds a pre-round binary32 + GRS to IEEE-754 and forms fflags; FP_ROUND_FFLAGS_ACC_EN adds a sticky flag accumulator.
// Latency 2 cycles accept->valid_o, 1 result/cycle.
// Backpressure: ready_i=0 holds the output and stalls S1 once both stages are full; clk_en_i=0 freezes everything.
module fp_round_unit
  import fp_round_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clk_en_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] unrounded_i,
  input  logic [2:0]  grs_i,
  input  logic        overflow_i,
  input  logic        underflow_i,
  input  logic        invalid_op_i,
  input  logic [2:0]  rnd_mode_i,
  output logic [31:0] result_o,
  output logic [4:0]  fflags_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [1:0]  fu_state_o
`ifdef FP_ROUND_FFLAGS_ACC_EN
  ,
  input  logic        fflags_clr_i,
  output logic [4:0]  fflags_acc_o
`endif
);

  logic       s1_v, s2_v, s2_take;
  float_t     s1_op;
  logic       s1_inc, s1_nx, s1_g, s1_ovf, s1_unf, s1_inv;
  logic [2:0] s1_mode;
  logic       inc, nx;

  assign ready_o    = clk_en_i & (~s1_v | ~s2_v | ready_i);
  assign s2_take    = clk_en_i & (~s2_v | ready_i);
  assign valid_o    = s2_v;
  assign fu_state_o = (s1_v | s2_v) ? FU_BUSY : FU_FREE;

  fp_round_incr u_incr (
    .sign     (unrounded_i[31]),
    .lsb      (unrounded_i[0]),
    .grs      (grs_i),
    .rnd_mode (rnd_mode_i),
    .inc      (inc),
    .nx       (nx)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_v    <= 1'b0;
      s1_op   <= '0;
      s1_inc  <= 1'b0;
      s1_nx   <= 1'b0;
      s1_g    <= 1'b0;
      s1_ovf  <= 1'b0;
      s1_unf  <= 1'b0;
      s1_inv  <= 1'b0;
      s1_mode <= 3'b000;
    end else if (ready_o) begin
      s1_v <= valid_i;
      if (valid_i) begin
        s1_op   <= unrounded_i;
        s1_inc  <= inc;
        s1_nx   <= nx;
        s1_g    <= grs_i[2];
        s1_ovf  <= overflow_i;
        s1_unf  <= underflow_i;
        s1_inv  <= invalid_op_i | (rnd_mode_i > 3'd4);
        s1_mode <= rnd_mode_i;
      end
    end
  end

  logic [30:0] sum;
  logic        rnd_ovf, to_inf;
  logic [31:0] nxt_res;
  fflags_t     nxt_flags;

  // Overflow is judged on the nearest-rounded magnitude: a value at least half an
  // ulp above MAX_FINITE flags OF even in modes that truncate back to MAX_FINITE.
  assign sum     = {s1_op.exp, s1_op.mant} + {30'b0, s1_inc};
  assign rnd_ovf = (sum[30:23] == 8'hFF) | (({s1_op.exp, s1_op.mant} == MAX_FINITE) & s1_g);
  assign to_inf  = (s1_mode == RM_RNE) | (s1_mode == RM_RMM) |
                   ((s1_mode == RM_RUP) & ~s1_op.sign) | ((s1_mode == RM_RDN) & s1_op.sign);

  always_comb begin
    nxt_res   = '0;
    nxt_flags = '0;
    if (s1_inv) begin
      nxt_res      = CANONICAL_NAN;
      nxt_flags.nv = 1'b1;
    end else if (s1_op.exp == 8'hFF) begin
      nxt_res = (s1_op.mant != 23'd0) ? CANONICAL_NAN : s1_op;
    end else if (s1_ovf | rnd_ovf) begin
      nxt_res      = {s1_op.sign, to_inf ? INF_MAG : MAX_FINITE};
      nxt_flags.of = 1'b1;
      nxt_flags.nx = 1'b1;
    end else if (s1_unf) begin
      nxt_res      = {s1_op.sign, 31'b0};
      nxt_flags.uf = 1'b1;
      nxt_flags.nx = 1'b1;
    end else begin
      nxt_res      = {s1_op.sign, sum};
      nxt_flags.nx = s1_nx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_v     <= 1'b0;
      result_o <= '0;
      fflags_o <= '0;
    end else if (s2_take) begin
      s2_v <= s1_v;
      if (s1_v) begin
        result_o <= nxt_res;
        fflags_o <= nxt_flags;
      end
    end
  end

`ifdef FP_ROUND_FFLAGS_ACC_EN
  // A clear coinciding with a handshake restarts the accumulator from the new flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fflags_acc_o <= '0;
    end else if (clk_en_i) begin
      if (valid_o & ready_i) begin
        fflags_acc_o <= fflags_clr_i ? fflags_o : (fflags_acc_o | fflags_o);
      end else if (fflags_clr_i) begin
        fflags_acc_o <= '0;
      end
    end
  end
`endif

endmodule
